// File: rtl/nonce_sweep_pkg.sv
// Shared state encoding, datapath widths and the difficulty mask helper
// for the nonce sweep controller and its result FIFO.
package nonce_sweep_pkg;

    localparam int NONCE_W   = 32;
    localparam int HASH_HI_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Top 'difficulty' bits set; values above 32 saturate to all ones.
    function automatic logic [HASH_HI_W-1:0] mask_for(
        input logic [5:0] difficulty
    );
        logic [HASH_HI_W-1:0] m;
        m = '0;
        for (int i = 0; i < HASH_HI_W; i++) begin
            if (i < int'(difficulty)) m[HASH_HI_W-1-i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/sweep_result_fifo.sv
// Multi-write, single-read FIFO: up to NUM_W lane-ordered pushes per cycle,
// one pop on rd_valid && rd_ready; count exposed for issue credit.
module sweep_result_fifo
    import nonce_sweep_pkg::*;
#(
    parameter int NUM_W = 2,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_W-1:0]           push_valid,
    input  logic [NONCE_W*NUM_W-1:0]   push_data,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [NONCE_W-1:0]         rd_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    logic [NONCE_W-1:0] mem [2**AW];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [AW-1:0]      wr_idx [NUM_W];
    logic [CW-1:0]      n_push;
    logic               pop;

    // Active lanes are packed into consecutive slots in lane order.
    always_comb begin
        n_push = '0;
        for (int i = 0; i < NUM_W; i++) begin
            wr_idx[i] = wr_ptr + AW'(n_push);
            if (push_valid[i]) n_push = n_push + CW'(1);
        end
    end

    assign rd_valid = (count != '0);
    assign pop      = rd_valid && rd_ready;
    assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_W; i++) begin
            if (push_valid[i]) begin
                mem[wr_idx[i]] <= push_data[NONCE_W*i +: NONCE_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(n_push);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + n_push - CW'(pop);
        end
    end

endmodule

// File: rtl/nonce_sweep_ctrl.sv
// Sweeps a nonce range over NUM_CORES fixed-latency hash lanes and queues
// results meeting the difficulty; job control via start/abort, busy/done.
module nonce_sweep_ctrl
    import nonce_sweep_pkg::*;
#(
    parameter int NUM_CORES   = 2,
    parameter int PIPE_LAT    = 4,
    parameter int FIFO_DEPTH  = 16,
    parameter bit STOP_ON_HIT = 1'b0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic                           abort,
    input  logic [NONCE_W-1:0]             nonce_start,
    input  logic [NONCE_W-1:0]             nonce_end,
    input  logic [5:0]                     difficulty,
    output logic [NUM_CORES-1:0]           core_issue_valid,
    output logic [NONCE_W*NUM_CORES-1:0]   core_nonce,
    input  logic [NUM_CORES-1:0]           core_res_valid,
    input  logic [HASH_HI_W*NUM_CORES-1:0] core_hash_hi,
    output logic                           res_valid,
    input  logic                           res_ready,
    output logic [NONCE_W-1:0]             res_nonce,
    output logic                           busy,
    output logic                           done,
    output logic [15:0]                    hit_count
);

    localparam int CW = $clog2(FIFO_DEPTH+1);

    state_t                       state;
    state_t                       state_nxt;
    logic [NONCE_W-1:0]           base;
    logic [NONCE_W-1:0]           end_r;
    logic [5:0]                   diff_r;
    logic [NUM_CORES-1:0]         sr_mask [PIPE_LAT];
    logic [NONCE_W-1:0]           sr_base [PIPE_LAT];
    logic [NUM_CORES-1:0]         lane_ok;
    logic [NUM_CORES-1:0]         issue_mask;
    logic [NUM_CORES-1:0]         hit_vec;
    logic [NUM_CORES-1:0]         push_vec;
    logic [NONCE_W*NUM_CORES-1:0] hit_data;
    logic [HASH_HI_W-1:0]         dmask;
    logic [CW-1:0]                fifo_count;
    logic [15:0]                  hc_next;
    logic                         credit_ok;
    logic                         pending;
    logic                         issue;
    logic                         covers_end;
    logic                         any_hit;
    logic                         start_ok;
    logic                         unused_res_valid;

    // The stored issue mask is authoritative; core strobes are not trusted.
    assign unused_res_valid = ^core_res_valid;

    assign dmask    = mask_for(diff_r);
    assign start_ok = start && (state == ST_IDLE || state == ST_DONE);
    assign busy     = (state == ST_RUN) || (state == ST_DRAIN);
    assign done     = (state == ST_DONE);

    // Credit counts every lane still in the delay line, including the one
    // being retired this cycle, so the FIFO can never overflow.
    always_comb begin
        int inflight;
        inflight = 0;
        pending  = 1'b0;
        for (int k = 0; k < PIPE_LAT; k++) begin
            for (int i = 0; i < NUM_CORES; i++) begin
                inflight += sr_mask[k][i] ? 1 : 0;
            end
            if (k < PIPE_LAT-1 && |sr_mask[k]) pending = 1'b1;
        end
        credit_ok = (int'(fifo_count) + inflight + NUM_CORES) <= FIFO_DEPTH;
    end

    // 33-bit compares keep nonce_end = FFFFFFFF from wrapping.
    always_comb begin
        lane_ok = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            lane_ok[i] = ({1'b0, base} + 33'(i)) <= {1'b0, end_r};
        end
    end

    assign covers_end = ({1'b0, base} + 33'(NUM_CORES)) > {1'b0, end_r};

    always_comb begin
        hit_vec  = '0;
        hit_data = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            hit_vec[i] = sr_mask[PIPE_LAT-1][i] &&
                ((core_hash_hi[HASH_HI_W*i +: HASH_HI_W] & dmask) == '0);
            hit_data[NONCE_W*i +: NONCE_W] =
                sr_base[PIPE_LAT-1] + NONCE_W'(i);
        end
    end

    assign any_hit    = |hit_vec;
    assign push_vec   = abort ? '0 : hit_vec;
    assign issue      = (state == ST_RUN) && credit_ok &&
                        !(STOP_ON_HIT && any_hit);
    assign issue_mask = issue ? lane_ok : '0;

    assign core_issue_valid = issue_mask;

    always_comb begin
        core_nonce = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            core_nonce[NONCE_W*i +: NONCE_W] =
                issue ? base + NONCE_W'(i) : '0;
        end
    end

    always_comb begin
        int sum;
        sum = int'(hit_count);
        for (int i = 0; i < NUM_CORES; i++) begin
            sum += hit_vec[i] ? 1 : 0;
        end
        hc_next = (sum > 65535) ? 16'hFFFF : 16'(sum);
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_nxt = (nonce_end < nonce_start) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if ((issue && covers_end) || (STOP_ON_HIT && any_hit)) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!pending) state_nxt = ST_DONE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            base      <= '0;
            end_r     <= '0;
            diff_r    <= '0;
            hit_count <= '0;
            for (int k = 0; k < PIPE_LAT; k++) begin
                sr_mask[k] <= '0;
                sr_base[k] <= '0;
            end
        end else if (abort) begin
            state <= ST_IDLE;
            for (int k = 0; k < PIPE_LAT; k++) begin
                sr_mask[k] <= '0;
            end
        end else begin
            state      <= state_nxt;
            sr_mask[0] <= issue_mask;
            sr_base[0] <= base;
            for (int k = 1; k < PIPE_LAT; k++) begin
                sr_mask[k] <= sr_mask[k-1];
                sr_base[k] <= sr_base[k-1];
            end
            if (start_ok) begin
                base      <= nonce_start;
                end_r     <= nonce_end;
                diff_r    <= difficulty;
                hit_count <= '0;
            end else begin
                hit_count <= hc_next;
                if (issue) base <= base + NONCE_W'(NUM_CORES);
            end
        end
    end

    sweep_result_fifo #(
        .NUM_W (NUM_CORES),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_valid (push_vec),
        .push_data  (hit_data),
        .rd_valid   (res_valid),
        .rd_ready   (res_ready),
        .rd_data    (res_nonce),
        .count      (fifo_count)
    );

endmodule

// File: tb/tb_nonce_sweep_ctrl.sv
// Directed bench: three controller builds (default, 4-deep FIFO,
// stop-on-hit) each fed by a 4-cycle behavioural hash-core model.
module tb_nonce_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  start;
    logic [2:0]  res_ready;
    logic        abort;
    logic [31:0] ns;
    logic [31:0] ne;
    logic [5:0]  diff;

    logic [1:0]  civ [3];
    logic [63:0] cn  [3];
    logic [1:0]  crv [3];
    logic [63:0] chh [3];
    logic [2:0]  rv;
    logic [2:0]  bz;
    logic [2:0]  dn;
    logic [31:0] rn  [3];
    logic [15:0] hc  [3];

    logic [31:0] hit_a;
    logic [31:0] hit_b;
    logic [31:0] near;
    logic [31:0] hit_val;

    int          sel;
    logic [31:0] got[$];
    logic [31:0] issued[$];
    int          n_issue;
    int          checks;
    int          errors;
    int          cyc;

    always #5 clk = ~clk;

    function automatic logic [31:0] hash_of(input logic [31:0] n);
        if (n == hit_a || n == hit_b) return hit_val;
        if (n == near) return 32'h01FF_FFFF;
        return 32'hFFFF_FFFF;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic [1:0]  pv [4];
        logic [63:0] ph [4];

        nonce_sweep_ctrl #(
            .NUM_CORES   (2),
            .PIPE_LAT    (4),
            .FIFO_DEPTH  ((g == 1) ? 4 : 16),
            .STOP_ON_HIT (g == 2)
        ) u_dut (
            .clk              (clk),
            .rst_n            (rst_n),
            .start            (start[g]),
            .abort            (abort),
            .nonce_start      (ns),
            .nonce_end        (ne),
            .difficulty       (diff),
            .core_issue_valid (civ[g]),
            .core_nonce       (cn[g]),
            .core_res_valid   (crv[g]),
            .core_hash_hi     (chh[g]),
            .res_valid        (rv[g]),
            .res_ready        (res_ready[g]),
            .res_nonce        (rn[g]),
            .busy             (bz[g]),
            .done             (dn[g]),
            .hit_count        (hc[g])
        );

        always @(posedge clk) begin
            pv[0] <= civ[g];
            ph[0] <= {hash_of(cn[g][63:32]), hash_of(cn[g][31:0])};
            for (int k = 1; k < 4; k++) begin
                pv[k] <= pv[k-1];
                ph[k] <= ph[k-1];
            end
        end

        assign crv[g] = pv[3];
        assign chh[g] = ph[3];
    end

    always @(negedge clk) begin
        if (rv[sel] && res_ready[sel]) got.push_back(rn[sel]);
        if (|civ[sel]) begin
            n_issue++;
            for (int l = 0; l < 2; l++) begin
                if (civ[sel][l]) issued.push_back(cn[sel][32*l +: 32]);
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic check_q(input string tag, input logic [31:0] q[$],
                           input logic [31:0] first, input int n);
        check({tag, "_len"}, q.size(), n);
        for (int i = 0; i < n && i < q.size(); i++) begin
            check(tag, q[i], first + 32'(i));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon(input int g);
        sel = g;
        got.delete();
        issued.delete();
        n_issue = 0;
    endtask

    task automatic go(input int g, input logic [31:0] s,
                      input logic [31:0] e, input logic [5:0] d);
        tick();
        ns       = s;
        ne       = e;
        diff     = d;
        start[g] = 1'b1;
        tick();
        start[g] = 1'b0;
    endtask

    task automatic wait_done(input int g, input int budget, output int c);
        c = 0;
        while (!dn[g] && c < budget) begin
            @(posedge clk);
            @(negedge clk);
            c++;
        end
        check("done_seen", dn[g], 1);
    endtask

    task automatic wait_fill(input int n);
        for (int i = 0; i < 80 && got.size() < n; i++) @(negedge clk);
        repeat (3) @(negedge clk);
    endtask

    task automatic no_hits();
        hit_a   = '1;
        hit_b   = '1;
        near    = '1;
        hit_val = '1;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        start     = '0;
        res_ready = '0;
        abort     = 1'b0;
        ns        = '0;
        ne        = '0;
        diff      = '0;
        no_hits();
        clear_mon(0);
        repeat (3) tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_res_valid", rv[0], 0);
        check("rst_busy", bz[0], 0);
        check("rst_done", dn[0], 0);
        check("rst_hit_count", hc[0], 0);
        check("rst_issue", civ[0], 0);
        check("rst_nonce", cn[0], 0);
        check("rst_res_nonce", rn[0], 0);

        // Full range at difficulty 0: every nonce is a hit.
        clear_mon(0);
        res_ready[0] = 1'b1;
        go(0, 32'd0, 32'd7, 6'd0);
        wait_done(0, 40, cyc);
        check("t1_done_latency", cyc, 8);
        wait_fill(8);
        check("t1_issues", n_issue, 4);
        check_q("t1_issued", issued, 32'd0, 8);
        check_q("t1_results", got, 32'd0, 8);
        check("t1_hit_count", hc[0], 8);

        // Difficulty 32, hash zero at 11 and at masked lane 13.
        no_hits();
        hit_a   = 32'd11;
        hit_b   = 32'd13;
        hit_val = 32'h0;
        clear_mon(0);
        go(0, 32'd10, 32'd12, 6'd32);
        wait_done(0, 40, cyc);
        wait_fill(1);
        check("t2_issues", n_issue, 2);
        check_q("t2_issued", issued, 32'd10, 3);
        check_q("t2_results", got, 32'd11, 1);
        check("t2_hit_count", hc[0], 1);

        // Top of the 32-bit range must not wrap.
        no_hits();
        clear_mon(0);
        go(0, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 6'd0);
        wait_done(0, 40, cyc);
        check("t3_done_latency", cyc, 5);
        wait_fill(2);
        check("t3_issues", n_issue, 1);
        check_q("t3_results", got, 32'hFFFF_FFFE, 2);
        check("t3_hit_count", hc[0], 2);
        check("t3_busy", bz[0], 0);

        // Four-entry FIFO with no consumer: issue must stall, nothing lost.
        clear_mon(1);
        res_ready[1] = 1'b0;
        go(1, 32'd0, 32'd15, 6'd0);
        repeat (20) @(negedge clk);
        check("t4_stall_issues", n_issue, 2);
        check("t4_stall_issue_valid", civ[1], 0);
        check("t4_stall_res_valid", rv[1], 1);
        check("t4_stall_busy", bz[1], 1);
        check("t4_stall_popped", got.size(), 0);
        tick();
        res_ready[1] = 1'b1;
        wait_done(1, 200, cyc);
        wait_fill(16);
        check_q("t4_results", got, 32'd0, 16);
        check("t4_issues", n_issue, 8);
        check("t4_hit_count", hc[1], 16);

        // Stop-on-hit: hit at 3 stops issue, in-flight hit at 6 still lands,
        // 5 (seven leading zeros) misses difficulty 8.
        no_hits();
        hit_a   = 32'd3;
        hit_b   = 32'd6;
        near    = 32'd5;
        hit_val = 32'h00FF_FFFF;
        clear_mon(2);
        res_ready[2] = 1'b1;
        go(2, 32'd0, 32'd15, 6'd8);
        wait_done(2, 40, cyc);
        check("t5_done_latency", cyc, 9);
        wait_fill(2);
        check("t5_issues", n_issue, 5);
        check_q("t5_issued", issued, 32'd0, 10);
        check("t5_result_count", got.size(), 2);
        if (got.size() == 2) begin
            check("t5_result0", got[0], 32'd3);
            check("t5_result1", got[1], 32'd6);
        end
        check("t5_hit_count", hc[2], 2);

        // Abort on the second RUN cycle with two results already queued.
        no_hits();
        clear_mon(0);
        res_ready[0] = 1'b0;
        go(0, 32'd100, 32'd101, 6'd0);
        wait_done(0, 40, cyc);
        repeat (3) @(negedge clk);
        check("t6_prequeue_valid", rv[0], 1);
        clear_mon(0);
        go(0, 32'd0, 32'd7, 6'd0);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge clk);
        check("t6_abort_busy", bz[0], 0);
        check("t6_abort_done", dn[0], 0);
        check("t6_abort_issue", civ[0], 0);
        check("t6_abort_issues", n_issue, 2);
        repeat (10) @(negedge clk);
        check("t6_hit_count", hc[0], 0);
        check("t6_kept_valid", rv[0], 1);
        tick();
        res_ready[0] = 1'b1;
        wait_fill(2);
        repeat (5) @(negedge clk);
        check_q("t6_kept", got, 32'd100, 2);

        // Reset in the middle of a job.
        clear_mon(0);
        res_ready[0] = 1'b0;
        go(0, 32'd0, 32'd15, 6'd0);
        repeat (8) @(negedge clk);
        check("t7_pre_valid", rv[0], 1);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("t7_res_valid", rv[0], 0);
        check("t7_busy", bz[0], 0);
        check("t7_done", dn[0], 0);
        check("t7_hit_count", hc[0], 0);
        check("t7_issue", civ[0], 0);
        check("t7_res_nonce", rn[0], 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/nonce_sweep_ctrl.md
Name: nonce_sweep_ctrl

Overview:
- Parametrised successor to the single-core, fixed-difficulty miner benchmark.
- Sweeps a programmable nonce range across NUM_CORES external fixed-latency SHA-256d hash cores, each core taking one nonce per cycle.
- Checks a runtime difficulty (count of leading zero bits) against each core result and queues golden nonces in a result FIFO with a valid/ready interface.
- Sits between the benchmark top (job control, $display of results) and the hash cores.

Parameters:
- NUM_CORES, 2, number of hash lanes (1..8); lane i hashes base+i.
- PIPE_LAT, 4, fixed core latency in cycles from core_issue_valid to core_res_valid.
- FIFO_DEPTH, 16, result FIFO entries (>= NUM_CORES, power of 2).
- STOP_ON_HIT, 0, 1 = stop issuing after the first hit in a job.

Ports:
- clk  in  1  clock (the benchmark top connects clock.val).
- rst_n  in  1  reset; synchronous, active-low.
- start  in  1  1-cycle pulse; accepted only in IDLE or DONE.
- abort  in  1  return to IDLE; in-flight lanes are discarded.
- nonce_start  in  32  first nonce, inclusive.
- nonce_end  in  32  last nonce, inclusive.
- difficulty  in  6  required leading zero bits of hash[255:224], 0..32.
- core_issue_valid  out  NUM_CORES  per-lane issue strobe.
- core_nonce  out  32*NUM_CORES  lane i nonce at bits [32i+31:32i].
- core_res_valid  in  NUM_CORES  per-lane result strobe, PIPE_LAT after issue.
- core_hash_hi  in  32*NUM_CORES  bits [255:224] of the lane's final hash.
- res_valid  out  1  FIFO head valid.
- res_ready  in  1  consumer accept.
- res_nonce  out  32  golden nonce at the FIFO head.
- busy  out  1  state is RUN or DRAIN.
- done  out  1  state is DONE.
- hit_count  out  16  hits in the current job, saturating.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - State IDLE; all outputs 0; FIFO emptied; hit_count 0.
  - The in-flight nonce delay line is cleared.
- States IDLE, RUN, DRAIN, DONE.
- start in IDLE or DONE:
  - Latch nonce_start, nonce_end and difficulty; set base = nonce_start; clear hit_count.
  - Go to RUN. The FIFO is not cleared.
  - If nonce_end < nonce_start, go straight to DONE with no issue.
- start in RUN or DRAIN is ignored.
- RUN, per cycle:
  - Issue is allowed when fifo_count + inflight_lanes + NUM_CORES <= FIFO_DEPTH. This credit rule guarantees the FIFO never overflows.
  - When issue is not allowed, all core_issue_valid are 0 (a pipeline bubble) and base holds.
  - When issuing, lane i gets valid = (base+i <= nonce_end); compute in 33 bits so nonce_end = FFFFFFFF does not wrap.
  - base += NUM_CORES after each issue.
  - Go to DRAIN when the issue covers nonce_end, or when STOP_ON_HIT=1 and any hit is enqueued.
- Nonce tracking:
  - Each issue pushes {valid mask, base} into a PIPE_LAT-deep shift register.
  - Results are paired with the register output. A core_res_valid mismatch against the stored mask is a core fault; it is ignored and the stored mask governs.
- Hit rule: lane valid && (difficulty==0 || core_hash_hi[31 -: difficulty]==0).
- All hits in a cycle are enqueued in the same cycle, in ascending lane order (multi-write FIFO, up to NUM_CORES writes per cycle).
- Hits arriving in DRAIN (including after STOP_ON_HIT) are still enqueued.
- DRAIN: wait until the shift register holds no valid lanes (at most PIPE_LAT cycles), then go to DONE.
- DONE: done=1 is held until start or abort.
- abort (any state, rst_n high):
  - Next state IDLE; shift register cleared; core_issue_valid 0 from the next cycle.
  - The FIFO and its contents are retained.
  - abort beats start in the same cycle.
- FIFO:
  - res_valid = not empty; pop on res_valid && res_ready.
  - Push and pop in the same cycle are legal.
  - The count is updated by pushes minus pop.
- hit_count saturates at FFFF.

Decomposition:
- Package nonce_sweep_pkg holds:
  - the state enum;
  - NONCE_W=32 and HASH_HI_W=32;
  - the leading-zero mask function mask_for(difficulty).
- One sub-module: sweep_result_fifo, a multi-write (NUM_CORES ports, packed in lane order) single-read FIFO that exposes count.

Test Plan:
- NUM_CORES=2, PIPE_LAT=4, range 0..7, difficulty 0, res_ready=1 -> issues at bases 0,2,4,6; res_nonce sequence 0..7; done 4+4 cycles after start; hit_count 8.
- Range 10..12, difficulty 32, core returns hash_hi=0 only for nonce 11 -> lane 1 of the second issue is masked (nonce 13 > end); exactly one result, 11.
- Range FFFFFFFE..FFFFFFFF, difficulty 0 -> one issue with both lanes valid; results FFFFFFFE, FFFFFFFF; no wrap to 0; DONE.
- FIFO_DEPTH=4, res_ready=0, difficulty 0, range 0..15 -> issue stalls with the FIFO at 4 entries and no loss; asserting res_ready releases 0..15 in order.
- STOP_ON_HIT=1, hit only at nonce 3 -> issuing stops in the cycle the hit is enqueued; in-flight hits still drained; done; hit_count 1.
- abort on the 2nd RUN cycle with 2 results queued -> IDLE next cycle; in-flight hits not enqueued; FIFO keeps its 2 entries.
- rst_n low mid-job -> outputs 0 and FIFO empty the next cycle.
